cv32e40p_tb_harness: RTL and testbench

Simulation-only system wrapper around the existing cv32e40p_core. It adds a dual-port word RAM with instruction and data ports and a small memory-mapped peripheral block for stdout, pass/fail and exit reporting. It exposes only clock, reset, fetch enable and test-status outputs to the testbench top. The RAM array is reachable by hierarchical path ram_i.dp_ram_i.mem for $readmemh preload.

---
 rtl/cv32e40p_tb_harness.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_cv32e40p_tb_harness.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tb_harness.sv
// Simulation wrapper: cv32e40p_core with a dual-port word RAM and stdout/status/exit peripherals.
// TB_STDOUT_EN prints stdout writes; CV32E40P_CORE_PRESENT must be defined when RISC_TOP=1.

module cv32e40p_tb_harness_dp_ram #(
    parameter int ADDR_WIDTH        = 5,
    parameter int INSTR_RDATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         en_a_i,
    input  logic [ADDR_WIDTH-1:0]        addr_a_i,
    output logic [INSTR_RDATA_WIDTH-1:0] rdata_a_o,
    input  logic                         en_b_i,
    input  logic                         we_b_i,
    input  logic [3:0]                   be_b_i,
    input  logic [ADDR_WIDTH-1:0]        addr_b_i,
    input  logic [31:0]                  wdata_b_i,
    output logic [31:0]                  rdata_b_o
);
    localparam int NWORDS = INSTR_RDATA_WIDTH / 32;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] base_a;

    assign base_a = addr_a_i & ~ADDR_WIDTH'(NWORDS - 1);

    // Reads sample the array before this edge's write lands, so a colliding read sees old data.
    always_ff @(posedge clk_i) begin
        if (en_a_i) begin
            for (int k = 0; k < NWORDS; k++) begin
                rdata_a_o[32*k +: 32] <= mem[base_a + ADDR_WIDTH'(k)];
            end
        end
        if (en_b_i) begin
            if (we_b_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_b_i[i]) mem[addr_b_i][8*i +: 8] <= wdata_b_i[8*i +: 8];
                end
            end else begin
                rdata_b_o <= mem[addr_b_i];
            end
        end
    end
endmodule

module cv32e40p_tb_harness_mm_ram #(
    parameter int INSTR_RDATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH    = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
    input  logic                         data_req_i,
    input  logic [31:0]                  data_addr_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_wdata_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    output logic [31:0]                  data_rdata_o,
    output logic                         tests_passed_o,
    output logic                         tests_failed_o,
    output logic                         exit_valid_o,
    output logic [31:0]                  exit_value_o
);
    localparam logic [31:0] STDOUT_ADDR = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h2000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'h2000_0004;
    localparam logic [31:0] PASS_CODE   = 32'd123456789;
    localparam logic [31:0] FAIL_CODE   = 32'd1;

    if (INSTR_RDATA_WIDTH != 32 && INSTR_RDATA_WIDTH != 128) begin : g_bad_width
        $fatal(1, "cv32e40p_tb_harness: INSTR_RDATA_WIDTH must be 32 or 128");
    end

    logic [31:0]                  data_waddr;
    logic                         data_in_ram;
    logic                         instr_in_ram;
    logic                         is_stdout;
    logic                         is_status;
    logic                         is_exit;
    logic                         data_wr;
    logic                         unused_low_bits;
    logic [INSTR_RDATA_WIDTH-1:0] ram_rdata_a;
    logic [31:0]                  ram_rdata_b;

    logic        instr_rvalid_q;
    logic        instr_zero_q;
    logic        data_rvalid_q;
    logic        data_zero_q;
    logic        passed_q;
    logic        failed_q;
    logic        exit_valid_q;
    logic [31:0] exit_value_q;

    assign data_waddr      = {data_addr_i[31:2], 2'b00};
    assign data_in_ram     = (data_addr_i[31:RAM_ADDR_WIDTH+2] == '0);
    assign instr_in_ram    = (instr_addr_i[31:RAM_ADDR_WIDTH+2] == '0);
    assign is_stdout       = (data_waddr == STDOUT_ADDR);
    assign is_status       = (data_waddr == STATUS_ADDR);
    assign is_exit         = (data_waddr == EXIT_ADDR);
    assign data_wr         = data_req_i && data_we_i;
    assign unused_low_bits = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    assign instr_gnt_o    = instr_req_i;
    assign data_gnt_o     = data_req_i;
    assign instr_rvalid_o = instr_rvalid_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign instr_rdata_o  = instr_zero_q ? '0 : ram_rdata_a;
    assign data_rdata_o   = data_zero_q ? '0 : ram_rdata_b;
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;

    cv32e40p_tb_harness_dp_ram #(
        .ADDR_WIDTH        (RAM_ADDR_WIDTH),
        .INSTR_RDATA_WIDTH (INSTR_RDATA_WIDTH)
    ) dp_ram_i (
        .clk_i     (clk_i),
        .en_a_i    (instr_req_i && instr_in_ram),
        .addr_a_i  (instr_addr_i[RAM_ADDR_WIDTH+1:2]),
        .rdata_a_o (ram_rdata_a),
        .en_b_i    (data_req_i && data_in_ram),
        .we_b_i    (data_we_i),
        .be_b_i    (data_be_i),
        .addr_b_i  (data_addr_i[RAM_ADDR_WIDTH+1:2]),
        .wdata_b_i (data_wdata_i),
        .rdata_b_o (ram_rdata_b)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_rvalid_q <= 1'b0;
            instr_zero_q   <= 1'b0;
            data_rvalid_q  <= 1'b0;
            data_zero_q    <= 1'b0;
            passed_q       <= 1'b0;
            failed_q       <= 1'b0;
            exit_valid_q   <= 1'b0;
            exit_value_q   <= '0;
        end else begin
            instr_rvalid_q <= instr_req_i;
            instr_zero_q   <= !instr_in_ram;
            data_rvalid_q  <= data_req_i;
            data_zero_q    <= data_we_i || !data_in_ram;
            passed_q       <= data_wr && is_status && (data_wdata_i == PASS_CODE);
            failed_q       <= data_wr && is_status && (data_wdata_i == FAIL_CODE);
            exit_valid_q   <= data_wr && is_exit;
            if (data_wr && is_exit) exit_value_q <= data_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (data_req_i) begin
            if (is_stdout) begin
`ifdef TB_STDOUT_EN
                if (data_we_i) $write("%c", data_wdata_i[7:0]);
`endif
            end else if (!data_in_ram && !is_status && !is_exit) begin
                $warning("cv32e40p_tb_harness: access to unmapped address %08h", data_addr_i);
            end
        end
    end
endmodule

module cv32e40p_tb_harness #(
    parameter int          INSTR_RDATA_WIDTH = 32,
    parameter int          RAM_ADDR_WIDTH    = 5,
    parameter logic [31:0] BOOT_ADDR         = 32'h04,
    parameter int          RISC_TOP          = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_enable_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    logic                         instr_req;
    logic [31:0]                  instr_addr;
    logic                         instr_gnt;
    logic                         instr_rvalid;
    logic [INSTR_RDATA_WIDTH-1:0] instr_rdata;
    logic                         data_req;
    logic [31:0]                  data_addr;
    logic                         data_we;
    logic [3:0]                   data_be;
    logic [31:0]                  data_wdata;
    logic                         data_gnt;
    logic                         data_rvalid;
    logic [31:0]                  data_rdata;

    cv32e40p_tb_harness_mm_ram #(
        .INSTR_RDATA_WIDTH (INSTR_RDATA_WIDTH),
        .RAM_ADDR_WIDTH    (RAM_ADDR_WIDTH)
    ) ram_i (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_addr_i    (data_addr),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .tests_passed_o (tests_passed_o),
        .tests_failed_o (tests_failed_o),
        .exit_valid_o   (exit_valid_o),
        .exit_value_o   (exit_value_o)
    );

    if (RISC_TOP != 0) begin : g_core
`ifdef CV32E40P_CORE_PRESENT
        // The core fetches 32-bit words; a wide fetch bus hands it the lowest word of the block.
        cv32e40p_core core_i (
            .clk_i               (clk_i),
            .rst_ni              (rst_ni),
            .pulp_clock_en_i     (1'b1),
            .scan_cg_en_i        (1'b0),
            .boot_addr_i         (BOOT_ADDR),
            .mtvec_addr_i        (32'h0),
            .dm_halt_addr_i      (32'h0),
            .hart_id_i           (32'h0),
            .dm_exception_addr_i (32'h0),
            .instr_req_o         (instr_req),
            .instr_gnt_i         (instr_gnt),
            .instr_rvalid_i      (instr_rvalid),
            .instr_addr_o        (instr_addr),
            .instr_rdata_i       (instr_rdata[31:0]),
            .data_req_o          (data_req),
            .data_gnt_i          (data_gnt),
            .data_rvalid_i       (data_rvalid),
            .data_we_o           (data_we),
            .data_be_o           (data_be),
            .data_addr_o         (data_addr),
            .data_wdata_o        (data_wdata),
            .data_rdata_i        (data_rdata),
            .apu_req_o           (),
            .apu_gnt_i           (1'b0),
            .apu_operands_o      (),
            .apu_op_o            (),
            .apu_flags_o         (),
            .apu_rvalid_i        (1'b0),
            .apu_result_i        (32'h0),
            .apu_flags_i         (5'h0),
            .irq_i               (32'h0),
            .irq_ack_o           (),
            .irq_id_o            (),
            .debug_req_i         (1'b0),
            .debug_havereset_o   (),
            .debug_running_o     (),
            .debug_halted_o      (),
            .fetch_enable_i      (fetch_enable_i),
            .core_sleep_o        ()
        );
`else
        $fatal(1, "cv32e40p_tb_harness: RISC_TOP=1 needs CV32E40P_CORE_PRESENT and the core sources");
`endif
    end else begin : g_no_core
        logic unused_bus;

        assign instr_req  = 1'b0;
        assign instr_addr = '0;
        assign data_req   = 1'b0;
        assign data_addr  = '0;
        assign data_we    = 1'b0;
        assign data_be    = '0;
        assign data_wdata = '0;
        assign unused_bus = ^{fetch_enable_i, BOOT_ADDR, instr_gnt, instr_rvalid, instr_rdata,
                              data_gnt, data_rvalid, data_rdata};
    end
endmodule

// File: tb/tb_cv32e40p_tb_harness.sv
// Bench for cv32e40p_tb_harness: core-less top for reset behaviour, plus 32- and 128-bit
// memory subsystems driven directly on their buses and checked against an array model.

module tb_cv32e40p_tb_harness;
    localparam int          AW          = 5;
    localparam logic [31:0] RAM_BYTES   = 32'd128;
    localparam logic [31:0] STDOUT_ADDR = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h2000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'h2000_0004;
    localparam logic [31:0] PASS_CODE   = 32'd123456789;

    logic clk_sys  = 1'b0;
    logic rst_b    = 1'b0;
    logic fetch_en = 1'b0;

    always #5 clk_sys = ~clk_sys;

    logic        top_passed, top_failed, top_exit_valid;
    logic [31:0] top_exit_value;

    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    logic         i_gnt_w32, i_rv_w32, d_gnt_w32, d_rv_w32, pass_w32, fail_w32, ev_w32;
    logic [31:0]  i_rd_w32, d_rd_w32, exv_w32;
    logic         i_gnt_w128, i_rv_w128, d_gnt_w128, d_rv_w128, pass_w128, fail_w128, ev_w128;
    logic [127:0] i_rd_w128;
    logic [31:0]  d_rd_w128, exv_w128;

    logic [31:0] mem_m [2**AW];
    logic [31:0] exit_m = '0;

    int n_checks = 0;
    int n_errors = 0;

    cv32e40p_tb_harness #(.RISC_TOP(0)) dut (
        .clk_i          (clk_sys),
        .rst_ni         (rst_b),
        .fetch_enable_i (fetch_en),
        .tests_passed_o (top_passed),
        .tests_failed_o (top_failed),
        .exit_valid_o   (top_exit_valid),
        .exit_value_o   (top_exit_value)
    );

    cv32e40p_tb_harness_mm_ram #(.INSTR_RDATA_WIDTH(32), .RAM_ADDR_WIDTH(AW)) u_mm_w32 (
        .clk_i (clk_sys), .rst_ni (rst_b),
        .instr_req_i (i_req), .instr_addr_i (i_addr), .instr_gnt_o (i_gnt_w32),
        .instr_rvalid_o (i_rv_w32), .instr_rdata_o (i_rd_w32),
        .data_req_i (d_req), .data_addr_i (d_addr), .data_we_i (d_we), .data_be_i (d_be),
        .data_wdata_i (d_wdata), .data_gnt_o (d_gnt_w32), .data_rvalid_o (d_rv_w32),
        .data_rdata_o (d_rd_w32), .tests_passed_o (pass_w32), .tests_failed_o (fail_w32),
        .exit_valid_o (ev_w32), .exit_value_o (exv_w32)
    );

    cv32e40p_tb_harness_mm_ram #(.INSTR_RDATA_WIDTH(128), .RAM_ADDR_WIDTH(AW)) u_mm_w128 (
        .clk_i (clk_sys), .rst_ni (rst_b),
        .instr_req_i (i_req), .instr_addr_i (i_addr), .instr_gnt_o (i_gnt_w128),
        .instr_rvalid_o (i_rv_w128), .instr_rdata_o (i_rd_w128),
        .data_req_i (d_req), .data_addr_i (d_addr), .data_we_i (d_we), .data_be_i (d_be),
        .data_wdata_i (d_wdata), .data_gnt_o (d_gnt_w128), .data_rvalid_o (d_rv_w128),
        .data_rdata_o (d_rd_w128), .tests_passed_o (pass_w128), .tests_failed_o (fail_w128),
        .exit_valid_o (ev_w128), .exit_value_o (exv_w128)
    );

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_idle();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    endtask

    task automatic dwrite(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = wd; d_be = be;
    endtask

    task automatic dread(input logic [31:0] a);
        d_req = 1'b1; d_we = 1'b0; d_addr = a; d_be = 4'hF;
    endtask

    task automatic ifetch(input logic [31:0] a);
        i_req = 1'b1; i_addr = a;
    endtask

    task automatic check_top_idle();
        check_val("top_passed", 128'(top_passed), 128'(0));
        check_val("top_failed", 128'(top_failed), 128'(0));
        check_val("top_exit_valid", 128'(top_exit_valid), 128'(0));
        check_val("top_exit_value", 128'(top_exit_value), 128'(0));
    endtask

    // One bus cycle: predict from the model, clock once, compare, then commit the write.
    task automatic step();
        logic [31:0]   exp_i32, exp_d, wa;
        logic [127:0]  exp_i128;
        logic          exp_pass, exp_fail, exp_ev, d_wr, d_in;
        logic [AW-1:0] widx;
        #1;
        check_val("i_gnt32", 128'(i_gnt_w32), 128'(i_req));
        check_val("i_gnt128", 128'(i_gnt_w128), 128'(i_req));
        check_val("d_gnt32", 128'(d_gnt_w32), 128'(d_req));
        check_val("d_gnt128", 128'(d_gnt_w128), 128'(d_req));
        exp_i32  = '0;
        exp_i128 = '0;
        if (i_addr < RAM_BYTES) begin
            exp_i32 = mem_m[i_addr[AW+1:2]];
            for (int k = 0; k < 4; k++) begin
                widx = {i_addr[AW+1:4], 2'(k)};
                exp_i128[32*k +: 32] = mem_m[widx];
            end
        end
        d_in  = d_addr < RAM_BYTES;
        d_wr  = d_req && d_we;
        exp_d = (!d_we && d_in) ? mem_m[d_addr[AW+1:2]] : 32'h0;
        wa    = {d_addr[31:2], 2'b00};
        exp_pass = d_wr && wa == STATUS_ADDR && d_wdata == PASS_CODE;
        exp_fail = d_wr && wa == STATUS_ADDR && d_wdata == 32'd1;
        exp_ev   = d_wr && wa == EXIT_ADDR;
        if (exp_ev) exit_m = d_wdata;
        @(posedge clk_sys);
        #1;
        check_val("i_rvalid32", 128'(i_rv_w32), 128'(i_req));
        check_val("i_rvalid128", 128'(i_rv_w128), 128'(i_req));
        if (i_req) begin
            check_val("i_rdata32", 128'(i_rd_w32), 128'(exp_i32));
            check_val("i_rdata128", i_rd_w128, exp_i128);
        end
        check_val("d_rvalid32", 128'(d_rv_w32), 128'(d_req));
        check_val("d_rvalid128", 128'(d_rv_w128), 128'(d_req));
        if (d_req) begin
            check_val("d_rdata32", 128'(d_rd_w32), 128'(exp_d));
            check_val("d_rdata128", 128'(d_rd_w128), 128'(exp_d));
        end
        check_val("passed32", 128'(pass_w32), 128'(exp_pass));
        check_val("passed128", 128'(pass_w128), 128'(exp_pass));
        check_val("failed32", 128'(fail_w32), 128'(exp_fail));
        check_val("failed128", 128'(fail_w128), 128'(exp_fail));
        check_val("exit_valid32", 128'(ev_w32), 128'(exp_ev));
        check_val("exit_valid128", 128'(ev_w128), 128'(exp_ev));
        check_val("exit_value32", 128'(exv_w32), 128'(exit_m));
        check_val("exit_value128", 128'(exv_w128), 128'(exit_m));
        check_top_idle();
        if (d_wr && d_in) begin
            for (int b = 0; b < 4; b++) begin
                if (d_be[b]) mem_m[d_addr[AW+1:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end
        end
    endtask

    initial begin
        int sel;

        // Reset held four cycles with no requests.
        repeat (4) @(posedge clk_sys);
        #1;
        check_val("rst_i_rvalid32", 128'(i_rv_w32), 128'(0));
        check_val("rst_d_rvalid128", 128'(d_rv_w128), 128'(0));
        check_val("rst_passed32", 128'(pass_w32), 128'(0));
        check_val("rst_exit_value128", 128'(exv_w128), 128'(0));
        check_top_idle();
        @(negedge clk_sys);
        rst_b = 1'b1;
        repeat (3) step();

        // Bring RAM to a known all-zero state through the data port.
        for (int w = 0; w < 2**AW; w++) begin
            dwrite(32'(w * 4), 32'h0, 4'hF);
            step();
        end
        set_idle();

        // Word 1 = DEADBEEF, then fetch 0x04.
        dwrite(32'h4, 32'hDEAD_BEEF, 4'hF); step();
        set_idle(); ifetch(32'h4); step();
        check_val("fetch_deadbeef", 128'(i_rd_w32), 128'(32'hDEAD_BEEF));

        // Byte-enable merge.
        set_idle(); dwrite(32'h10, 32'h1122_3344, 4'b0101); step();
        set_idle(); dread(32'h10); step();
        check_val("be_merge", 128'(d_rd_w32), 128'(32'h0022_0044));

        // Status pulses.
        set_idle(); dwrite(STATUS_ADDR, PASS_CODE, 4'hF); step();
        check_val("pass_pulse", 128'(pass_w32), 128'(1));
        set_idle(); step();
        check_val("pass_drop", 128'(pass_w32), 128'(0));
        dwrite(STATUS_ADDR, 32'd1, 4'hF); step();
        check_val("fail_pulse", 128'(fail_w128), 128'(1));
        set_idle(); dwrite(STATUS_ADDR, 32'd7, 4'hF); step();

        // Exit code.
        set_idle(); dwrite(EXIT_ADDR, 32'd0, 4'hF); step();
        check_val("exit0_valid", 128'(ev_w32), 128'(1));
        set_idle(); dwrite(EXIT_ADDR, 32'd5, 4'hF); step();
        check_val("exit5_value", 128'(exv_w32), 128'(5));
        set_idle(); step();

        // Wide fetch of block 0 holding 1,2,3,4.
        for (int w = 0; w < 4; w++) begin
            dwrite(32'(w * 4), 32'(w + 1), 4'hF);
            step();
        end
        set_idle(); ifetch(32'h4); step();
        check_val("fetch128_block", i_rd_w128, 128'h00000004_00000003_00000002_00000001);

        // Same-word write and fetch in one cycle, then out-of-range fetch and unmapped read.
        ifetch(32'h8); dwrite(32'h8, 32'hCAFE_F00D, 4'hF); step();
        check_val("collide_old", 128'(i_rd_w32), 128'(3));
        set_idle(); ifetch(32'h8); step();
        set_idle(); ifetch(RAM_BYTES + 32'h40); dread(32'h3000_0000); step();
        dwrite(STDOUT_ADDR, 32'h0000_0041, 4'hF); step();

        // Reset in the middle of traffic.
        set_idle(); ifetch(32'hC); dread(32'h8); step();
        rst_b = 1'b0;
        #1;
        check_val("midrst_d_rvalid", 128'(d_rv_w32), 128'(0));
        check_val("midrst_i_rvalid", 128'(i_rv_w128), 128'(0));
        set_idle(); dwrite(STATUS_ADDR, PASS_CODE, 4'hF);
        @(posedge clk_sys);
        #1;
        check_val("midrst_no_pass", 128'(pass_w32), 128'(0));
        exit_m = '0;
        check_val("midrst_exit_value", 128'(exv_w32), 128'(exit_m));
        set_idle();
        @(negedge clk_sys);
        rst_b = 1'b1;
        repeat (2) step();

        // Randomized traffic on both ports every cycle.
        for (int n = 0; n < 600; n++) begin
            i_req  = $urandom_range(0, 3) != 0;
            i_addr = ($urandom_range(0, 7) == 0) ? RAM_BYTES + 32'($urandom_range(0, 4095))
                                                 : 32'($urandom_range(0, 127));
            d_req   = $urandom_range(0, 3) != 0;
            d_we    = 1'($urandom_range(0, 1));
            d_be    = 4'($urandom_range(0, 15));
            d_wdata = $urandom;
            sel     = int'($urandom_range(0, 59));
            if (sel < 48) begin
                d_addr = 32'($urandom_range(0, 127));
            end else if (sel < 53) begin
                d_addr = STATUS_ADDR | 32'($urandom_range(0, 3));
                case ($urandom_range(0, 2))
                    0: d_wdata = PASS_CODE;
                    1: d_wdata = 32'd1;
                    default: d_wdata = $urandom;
                endcase
            end else if (sel < 57) begin
                d_addr = EXIT_ADDR;
            end else if (sel < 59) begin
                d_addr = STDOUT_ADDR;
            end else begin
                d_addr = 32'h3000_0000 | 32'($urandom_range(0, 255));
            end
            step();
        end
        set_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
